// File: rtl/uart_word_tx_sequencer_if.sv
// Word-side handshake and byte-side UART strobes of uart_word_tx_sequencer.
// The master modport is the environment: the word requester plus the UART TX core.
interface uart_word_tx_sequencer_if #(
  parameter int NBITS = 32
);
  logic             word_valid;
  logic [NBITS-1:0] word_data;
  logic             word_ready;
  logic             word_done;
  logic             busy;
  logic [7:0]       byte_data;
  logic             byte_start;
  logic             byte_done;

  modport master (
    output word_valid, word_data, byte_done,
    input  word_ready, word_done, busy, byte_data, byte_start
  );

  modport slave (
    input  word_valid, word_data, byte_done,
    output word_ready, word_done, busy, byte_data, byte_start
  );
endinterface

// File: rtl/uart_word_tx_sequencer.sv
// Splits one NBITS word into bytes and handshakes each one with the UART TX core.
// Optional macro TX_CHECKSUM_EN appends an XOR-of-all-bytes checksum byte per word.
module uart_word_tx_sequencer #(
  parameter int NBITS     = 32,
  parameter int MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_word_tx_sequencer_if.slave  bus
);
  localparam int NBYTES = NBITS / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

`ifdef TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SEND, WAIT, CHK_SEND, CHK_WAIT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE} state_t;
`endif

  state_t           state, state_n;
  logic [NBITS-1:0] word_q, word_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       byte_data_q, byte_data_n;
  logic             byte_start_q, byte_start_n;
  logic             word_done_q, word_done_n;

  // Transmission slot i maps to byte i, or mirrored when the MSB goes first.
  function automatic logic [7:0] byte_sel(input logic [NBITS-1:0] w,
                                          input logic [IDX_W-1:0] i);
    int pos;
    pos = (MSB_FIRST != 0) ? (NBYTES - 1 - int'(i)) : int'(i);
    return 8'(w >> (8 * pos));
  endfunction

`ifdef TX_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [NBITS-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < NBYTES; k++) acc = acc ^ 8'(w >> (8 * k));
    return acc;
  endfunction
`endif

  // Outputs are computed one cycle ahead so byte_start and word_done are registered
  // and line up exactly with the SEND/CHK_SEND and DONE states.
  always_comb begin
    state_n      = state;
    word_n       = word_q;
    idx_n        = idx;
    byte_data_n  = byte_data_q;
    byte_start_n = 1'b0;
    word_done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.word_valid) begin
          word_n       = bus.word_data;
          idx_n        = '0;
          state_n      = SEND;
          byte_start_n = 1'b1;
          byte_data_n  = byte_sel(bus.word_data, '0);
        end
      end
      SEND: state_n = WAIT;
      WAIT: begin
        if (bus.byte_done) begin
          if (idx == LAST_IDX) begin
`ifdef TX_CHECKSUM_EN
            state_n      = CHK_SEND;
            byte_start_n = 1'b1;
            byte_data_n  = xor_bytes(word_q);
`else
            state_n      = DONE;
            word_done_n  = 1'b1;
`endif
          end else begin
            idx_n        = idx + 1'b1;
            state_n      = SEND;
            byte_start_n = 1'b1;
            byte_data_n  = byte_sel(word_q, idx + 1'b1);
          end
        end
      end
`ifdef TX_CHECKSUM_EN
      CHK_SEND: state_n = CHK_WAIT;
      CHK_WAIT: begin
        if (bus.byte_done) begin
          state_n     = DONE;
          word_done_n = 1'b1;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_q       <= '0;
      idx          <= '0;
      byte_data_q  <= 8'h00;
      byte_start_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state        <= state_n;
      word_q       <= word_n;
      idx          <= idx_n;
      byte_data_q  <= byte_data_n;
      byte_start_q <= byte_start_n;
      word_done_q  <= word_done_n;
    end
  end

  assign bus.word_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_start = byte_start_q;
  assign bus.word_done  = word_done_q;
endmodule

// File: tb/tb_uart_word_tx_sequencer.sv
// Randomized bench for uart_word_tx_sequencer: an LSB-first and an MSB-first instance
// share one UART stub, checked against a cycle-level transaction model.
module tb_uart_word_tx_sequencer;
  localparam int NBITS = 32;
  localparam int NB    = NBITS / 8;
`ifdef TX_CHECKSUM_EN
  localparam int BPW = NB + 1;
`else
  localparam int BPW = NB;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_word_tx_sequencer_if #(.NBITS(NBITS)) if0 ();
  uart_word_tx_sequencer_if #(.NBITS(NBITS)) if1 ();

  uart_word_tx_sequencer #(.NBITS(NBITS), .MSB_FIRST(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  uart_word_tx_sequencer #(.NBITS(NBITS), .MSB_FIRST(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction model: a word in flight, the cycle its next byte_start is due,
  // and the cycles its word_done and the following idle cycle are due.
  bit         inflight  = 1'b0;
  int         start_due = -1;
  int         done_due  = -1;
  int         free_due  = -1;
  int         cnt       = 0;
  int         left      = 0;
  int         word_bd   = 0;
  int         acc_cnt   = 0;
  int         stub_delay = 10;
  bit         rand_delay = 1'b0;
  bit         spur_req   = 1'b0;
  bit         spur_send  = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] cur0, cur1;

  task automatic push_word(input logic [NBITS-1:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < NB; k++) begin
      q0.push_back(8'(w >> (8 * k)));
      q1.push_back(8'(w >> (8 * (NB - 1 - k))));
      x = x ^ 8'(w >> (8 * k));
    end
`ifdef TX_CHECKSUM_EN
    q0.push_back(x);
    q1.push_back(x);
`endif
  endtask

  always @(negedge clk) begin
    logic bd;
    bd = 1'b0;
    if (reset) begin
      inflight = 1'b0; start_due = -1; done_due = -1; free_due = -1; cnt = 0;
      q0.delete(); q1.delete();
    end else begin
      if (cyc == free_due) inflight = 1'b0;
      chk("ready0", if0.word_ready, !inflight);
      chk("ready1", if1.word_ready, !inflight);
      chk("busy0", if0.busy, inflight);
      chk("busy1", if1.busy, inflight);
      chk("word_done0", if0.word_done, cyc == done_due);
      chk("word_done1", if1.word_done, cyc == done_due);
      chk("byte_start0", if0.byte_start, cyc == start_due);
      chk("byte_start1", if1.byte_start, cyc == start_due);
      if (cyc == start_due) begin
        cur0 = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
        cur1 = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
        chk("byte_data0", if0.byte_data, cur0);
        chk("byte_data1", if1.byte_data, cur1);
        cnt = rand_delay ? int'($urandom_range(1, 8)) : stub_delay;
        if (spur_send) bd = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bd = 1'b1;
          chk("byte_hold0", if0.byte_data, cur0);
          chk("byte_hold1", if1.byte_data, cur1);
          left--;
          word_bd++;
          if (left == 0) begin
            done_due = cyc + 1;
            free_due = cyc + 2;
          end else begin
            start_due = cyc + 1;
          end
        end
      end
      if (if0.word_valid && !inflight) begin
        inflight  = 1'b1;
        start_due = cyc + 1;
        left      = BPW;
        word_bd   = 0;
        push_word(if0.word_data);
        acc_cnt++;
      end
      if (spur_req) begin
        bd = 1'b1;
        spur_req = 1'b0;
      end
    end
    if0.byte_done = bd;
    if1.byte_done = bd;
  end

  task automatic drive_word(input logic valid, input logic [NBITS-1:0] w);
    if0.word_valid = valid; if1.word_valid = valid;
    if0.word_data  = w;     if1.word_data  = w;
  endtask

  task automatic send_word(input logic [NBITS-1:0] w, input bit drop);
    int a;
    int n;
    a = acc_cnt;
    n = 0;
    drive_word(1'b1, w);
    while (acc_cnt == a && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_in_time", acc_cnt != a, 1);
    if (drop) drive_word(1'b0, $urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (inflight && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_in_time", inflight, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {if1.word_ready, if0.word_ready}, 2'b11);
    chk({tag, "_busy"}, {if1.busy, if0.busy}, 2'b00);
    chk({tag, "_start"}, {if1.byte_start, if0.byte_start}, 2'b00);
    chk({tag, "_done"}, {if1.word_done, if0.word_done}, 2'b00);
    chk({tag, "_bytes"}, {if1.byte_data, if0.byte_data}, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    drive_word(1'b0, '0);
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed: basic word, byte order, back-to-back words.
    stub_delay = 10;
    send_word(32'h11223344, 1'b1);
    wait_idle();
    send_word(32'hA1B2C3D4, 1'b1);
    wait_idle();
    stub_delay = 3;
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'h00000001, 1'b1);
    wait_idle();

    // Spurious byte_done in IDLE, alongside acceptance, and in the SEND cycle.
    spur_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    spur_req = 1'b1;
    spur_send = 1'b1;
    send_word(32'h55AA0FF0, 1'b1);
    wait_idle();
    spur_send = 1'b0;

    // Reset after the second byte_done, then a clean word.
    stub_delay = 4;
    send_word(32'hCAFEF00D, 1'b1);
    n = 0;
    while (word_bd < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("two_bytes_before_reset", word_bd, 2);
    reset = 1'b1;
    #1;
    check_reset_outputs("midword_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    send_word(32'h01020304, 1'b1);
    wait_idle();

    // Randomized words, UART delays, gaps and spurious done pulses.
    rand_delay = 1'b1;
    for (int i = 0; i < 25; i++) begin
      bit drop;
      drop = ($urandom_range(0, 3) != 0);
      if (!inflight && $urandom_range(0, 2) == 0) spur_req = 1'b1;
      spur_send = ($urandom_range(0, 3) == 0);
      send_word($urandom, drop);
      if (drop) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    drive_word(1'b0, '0);
    wait_idle();
    spur_send = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
